// File: rtl/cpu_pkg.sv
// Shared types and defaults for the data-memory controller slice.
package cpu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int RN_W_DEF   = 5;

  // Data written back for a load that timed out instead of being acked.
  localparam logic [31:0] TMO_LOAD_DATA = 32'h0;

endpackage

// File: rtl/dmem_wb_reg.sv
// MEM/WB pipeline register; a stall turns the slot into a bubble,
// and load data is only captured on the cycle a load completes.
module dmem_wb_reg import cpu_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RN_W   = RN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [RN_W-1:0]   mrn,
  input  logic [DATA_W-1:0] malu,
  input  logic              load_done,
  input  logic [DATA_W-1:0] load_data,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [RN_W-1:0]   wrn,
  output logic [DATA_W-1:0] wdo,
  output logic [DATA_W-1:0] walu
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wrn    <= '0;
      wdo    <= '0;
      walu   <= '0;
    end else begin
      if (stall) begin
        wwreg  <= 1'b0;
        wm2reg <= 1'b0;
      end else begin
        // A store never writes the register file, even with mm2reg also set.
        wwreg  <= mwreg & ~mwmem;
        wm2reg <= mm2reg & ~mwmem;
        wrn    <= mrn;
        walu   <= malu;
      end
      if (load_done) begin
        wdo <= load_data;
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer onto a req/ack data memory, with pipeline stall and
// MEM/WB register. Define DMEM_TIMEOUT_EN to abort accesses after TIMEOUT busy cycles.
module dmem_ctrl import cpu_pkg::*; #(
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int          RN_W    = RN_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mb,
  input  logic [RN_W-1:0]   mrn,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [RN_W-1:0]   wrn,
  output logic [DATA_W-1:0] wdo,
  output logic [DATA_W-1:0] walu,
  output logic              bus_err
);

  dmem_state_t       state;
  logic              access;
  logic              tmo;
  logic              done;
  logic              load_done;
  logic [DATA_W-1:0] load_data;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] busy_cnt;

  assign tmo = (state == BUSY) && !mem_ack && (busy_cnt == CNT_W'(TIMEOUT));
`else
  logic unused_timeout;

  assign tmo            = 1'b0;
  assign unused_timeout = ^TIMEOUT;
  assign bus_err        = 1'b0;
`endif

  assign access    = mm2reg | mwmem;
  assign done      = (state == BUSY) && (mem_ack || tmo);
  // Reset also releases the pipeline so nothing waits on an abandoned access.
  assign stall     = ~rst & (((state == IDLE) & access) | ((state == BUSY) & ~done));
  assign load_done = done & mm2reg & ~mwmem;
  assign load_data = tmo ? DATA_W'(TMO_LOAD_DATA) : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DMEM_TIMEOUT_EN
      busy_cnt  <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_addr  <= malu;
            mem_wdata <= mb;
            mem_we    <= mwmem;
            mem_req   <= 1'b1;
            state     <= BUSY;
`ifdef DMEM_TIMEOUT_EN
            busy_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (done) begin
            mem_req <= 1'b0;
            state   <= IDLE;
`ifdef DMEM_TIMEOUT_EN
            if (tmo) begin
              bus_err <= 1'b1;
            end
`endif
          end else begin
`ifdef DMEM_TIMEOUT_EN
            busy_cnt <= busy_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_wb_reg #(
    .DATA_W (DATA_W),
    .RN_W   (RN_W)
  ) u_wb_reg (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mwmem     (mwmem),
    .mrn       (mrn),
    .malu      (malu),
    .load_done (load_done),
    .load_data (load_data),
    .wwreg     (wwreg),
    .wm2reg    (wm2reg),
    .wrn       (wrn),
    .wdo       (wdo),
    .walu      (walu)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expected writeback results are queued when
// an instruction is driven and compared when it leaves the MEM/WB register.
module tb_dmem_ctrl;

  localparam int DATA_W  = 32;
  localparam int RN_W    = 5;
  localparam int TMO_CYC = 4;

  typedef struct {
    logic              wwreg;
    logic              wm2reg;
    logic [RN_W-1:0]   wrn;
    logic [DATA_W-1:0] walu;
    logic [DATA_W-1:0] wdo;
  } wb_exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              mwreg, mm2reg, mwmem;
  logic [DATA_W-1:0] malu, mb;
  logic [RN_W-1:0]   mrn;
  logic              stall, mem_req, mem_we;
  logic [DATA_W-1:0] mem_addr, mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wwreg, wm2reg;
  logic [RN_W-1:0]   wrn;
  logic [DATA_W-1:0] wdo, walu;
  logic              bus_err;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  logic [DATA_W-1:0] model_wdo = '0;
  wb_exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_W(DATA_W), .RN_W(RN_W), .TIMEOUT(TMO_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mwmem     (mwmem),
    .malu      (malu),
    .mb        (mb),
    .mrn       (mrn),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wwreg     (wwreg),
    .wm2reg    (wm2reg),
    .wrn       (wrn),
    .wdo       (wdo),
    .walu      (walu),
    .bus_err   (bus_err)
  );

  // Memory responder: one-cycle ack in the ack_delay-th request cycle (0 = never).
  always @(negedge clk) begin
    if (mem_req) begin
      ack_cnt = ack_cnt + 1;
      mem_ack = (ack_delay != 0) && (ack_cnt == ack_delay);
    end else begin
      ack_cnt = 0;
      mem_ack = 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    mwreg  = 1'b0;
    mm2reg = 1'b0;
    mwmem  = 1'b0;
    malu   = '0;
    mb     = '0;
    mrn    = '0;
  endtask

  // Drive one MEM-stage instruction and follow it to writeback.
  task automatic run_op(input string tag, input logic wr, input logic ld, input logic st,
                        input logic [RN_W-1:0] rn, input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] sdata, input int delay,
                        input logic [DATA_W-1:0] rdata);
    wb_exp_t e;
    int exp_cyc;
    int stall_n = 0;
    int req_n   = 0;
    bit fin     = 0;
    bit timed   = 0;
    mwreg = wr; mm2reg = ld; mwmem = st; mrn = rn; malu = alu; mb = sdata;
    ack_delay = delay;
    mem_rdata = rdata;
    timed   = (ld | st) && (delay == 0);
    exp_cyc = !(ld | st) ? 0 : (timed ? TMO_CYC + 1 : delay);
    if (ld && !st) model_wdo = timed ? '0 : rdata;
    e.wwreg  = wr & ~st;
    e.wm2reg = ld & ~st;
    e.wrn    = rn;
    e.walu   = alu;
    e.wdo    = model_wdo;
    sb_q.push_back(e);
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk); #1;
      if (mem_req) begin
        req_n++;
        check_val({tag, ".addr"}, mem_addr, alu);
        check_val({tag, ".we"}, DATA_W'(mem_we), DATA_W'(st));
        if (st) check_val({tag, ".wdata"}, mem_wdata, sdata);
      end
      if (stall) begin
        if (stall_n > 0) check_val({tag, ".bubble"}, DATA_W'(wwreg), '0);
        stall_n++;
      end else begin
        fin = 1;
      end
    end
    if (!fin) check_val({tag, ".stall_bound"}, '0, 1);
    check_val({tag, ".stall_cyc"}, DATA_W'(stall_n), DATA_W'(exp_cyc));
    check_val({tag, ".req_cyc"}, DATA_W'(req_n), DATA_W'(exp_cyc));
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check_val({tag, ".wwreg"}, DATA_W'(wwreg), DATA_W'(e.wwreg));
    check_val({tag, ".wm2reg"}, DATA_W'(wm2reg), DATA_W'(e.wm2reg));
    check_val({tag, ".wrn"}, DATA_W'(wrn), DATA_W'(e.wrn));
    check_val({tag, ".walu"}, walu, e.walu);
    check_val({tag, ".wdo"}, wdo, e.wdo);
  endtask

  initial begin
    wb_exp_t drop;
    set_idle();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.req", DATA_W'(mem_req), '0);
    check_val("rst.we", DATA_W'(mem_we), '0);
    check_val("rst.addr", mem_addr, '0);
    check_val("rst.wdata", mem_wdata, '0);
    check_val("rst.wwreg", DATA_W'(wwreg), '0);
    check_val("rst.wm2reg", DATA_W'(wm2reg), '0);
    check_val("rst.wrn", DATA_W'(wrn), '0);
    check_val("rst.wdo", wdo, '0);
    check_val("rst.walu", walu, '0);
    check_val("rst.bus_err", DATA_W'(bus_err), '0);
    check_val("rst.stall", DATA_W'(stall), '0);
    rst = 1'b0;

    run_op("alu",   1, 0, 0, 5'd3, 32'h10, 32'h0, 1, 32'h0);
    run_op("load3", 1, 1, 0, 5'd7, 32'h40, 32'h0, 3, 32'hCAFEF00D);
    run_op("store", 0, 0, 1, 5'd0, 32'h80, 32'h1234, 1, 32'hDEAD0000);
    run_op("b2b_ld", 1, 1, 0, 5'd9, 32'h44, 32'h0, 1, 32'h11112222);
    run_op("b2b_st", 0, 0, 1, 5'd2, 32'h48, 32'h5555, 1, 32'h0);
    run_op("illegal", 1, 1, 1, 5'd4, 32'h4C, 32'h7777, 2, 32'h99999999);
    run_op("alu2",  1, 0, 0, 5'd31, 32'hFFFF_FFFF, 32'h0, 1, 32'h0);
    run_op("load5", 1, 1, 0, 5'd12, 32'h50, 32'h0, 5, 32'h0BADBEEF);

    // Reset in the middle of an access that would never be acked.
    mwreg = 1; mm2reg = 1; mwmem = 0; mrn = 5'd6; malu = 32'h60;
    ack_delay = 0;
    @(posedge clk); @(negedge clk); #1;
    check_val("rstbusy.req_before", DATA_W'(mem_req), 1);
    rst = 1'b1;
    #1;
    check_val("rstbusy.req", DATA_W'(mem_req), '0);
    check_val("rstbusy.stall", DATA_W'(stall), '0);
    check_val("rstbusy.wwreg", DATA_W'(wwreg), '0);
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    model_wdo = '0;
    while (sb_q.size() > 0) drop = sb_q.pop_front();
    run_op("ld_after_rst", 1, 1, 0, 5'd8, 32'h64, 32'h0, 2, 32'hA5A5_5A5A);
    check_val("bus_err.clean", DATA_W'(bus_err), '0);

`ifdef DMEM_TIMEOUT_EN
    run_op("tmo_load", 1, 1, 0, 5'd10, 32'h70, 32'h0, 0, 32'hFFFF_0000);
    check_val("tmo.bus_err", DATA_W'(bus_err), 1);
    run_op("after_tmo", 1, 0, 0, 5'd11, 32'h22, 32'h0, 1, 32'h0);
    check_val("tmo.bus_err_sticky", DATA_W'(bus_err), 1);
`else
    run_op("no_tmo_alu", 1, 0, 0, 5'd11, 32'h22, 32'h0, 1, 32'h0);
    check_val("no_tmo.bus_err", DATA_W'(bus_err), '0);
`endif

    set_idle();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
